game_score_ctrl: RTL and testbench
==================================

# game_score_ctrl

Game-flow controller downstream of `mem_addr_gen`. It consumes the positive and negative score counters, runs a timed game round through a four-state FSM, and drives the reset of the falling-object generators. It tracks a final score and a high score, and multiplexes score and remaining time onto a 4-digit active-low seven-segment display.

## Interface
Parameters:
- `CLK_HZ`, default 100_000_000: clk_100MHz cycles per game second.
- `GAME_SECONDS`, default 60: round length, range 1..99.
- `WIN_SCORE`, default 50: net score that ends the round as a win, range 1..63.
- `SEG_REFRESH`, default 100_000: cycles each display digit stays lit.

Ports:
- `clk_100MHz`, in, 1: the only clock.
- `rst`, in, 1: reset, synchronous and active-low. Fixed.
- `start`, in, 1: start/advance request level from the keyboard path. Rising-edge detected internally.
- `score_pos`, in, 6: summed fruit score from `mem_addr_gen`.
- `score_neg`, in, 6: bug score from `mem_addr_gen`.
- `game_rst`, out, 1: active-high reset to `mem_addr_gen`.
- `state`, out, 2: 0 IDLE, 1 PLAY, 2 WIN, 3 LOSE.
- `net_score`, out, 6: live net score.
- `time_left`, out, 7: seconds remaining.
- `high_score`, out, 6: best final score since reset.
- `seg`, out, 7: {g,f,e,d,c,b,a}, active-low.
- `an`, out, 4: digit enables, active-low.

## Operation
**Input registration**
- `score_pos`, `score_neg` and `start` are registered once: `sp_q`, `sn_q`, `start_q`.
- `start_edge` = `start` & ~`start_q`.

**Net score**
- `net_score` is registered: (`sp_q` ≥ `sn_q`) ? `sp_q` − `sn_q` : 0. It saturates at 0 and never wraps negative.

**Second tick**
- A counter 0..CLK_HZ−1 runs only in PLAY. It is cleared on entry to PLAY.
- `tick` pulses for one cycle when the counter reaches CLK_HZ−1.

**FSM**
- IDLE:
  - On `start_edge`: go to PLAY, load `time_left` with GAME_SECONDS, clear the tick counter.
- PLAY, evaluated in priority order:
  1. If `net_score` ≥ WIN_SCORE: go to WIN. Latch `final_score` = `net_score`.
  2. Else, on `tick` with `time_left` == 1: set `time_left` to 0, go to LOSE, latch `final_score`.
  3. Else, on `tick`: decrement `time_left`.
  - `start_edge` is ignored in PLAY.
- WIN and LOSE:
  - Hold `time_left` and `final_score`.
  - On `start_edge`: go to IDLE and reload `time_left` with GAME_SECONDS.
- High score: on the cycle `final_score` is latched, if the new value > `high_score`, `high_score` takes it. Ties leave it unchanged.

**Reset of the object generators**
- `game_rst` is registered: 1 whenever the next state ≠ PLAY.
- So `mem_addr_gen` is held in reset in IDLE, WIN and LOSE, and released the same cycle `state` becomes PLAY.
- The live score therefore reads 0 outside PLAY. `final_score` preserves the round result.

**Display**
- Shown values by state:
  - PLAY: score = `net_score`, time = `time_left`.
  - WIN/LOSE: score = `final_score`, time = `time_left`.
  - IDLE: score = `high_score`, time = GAME_SECONDS.
- BCD: tens = value/10, ones = value%10, values 0..99. Use a combinational compare-subtract; no divider IP.
- Scan: a refresh counter 0..SEG_REFRESH−1. The digit index 0..3 advances on wrap, and index 3 wraps to 0.
  - Index 0: `an`=1110, score ones.
  - Index 1: `an`=1101, score tens.
  - Index 2: `an`=1011, time ones.
  - Index 3: `an`=0111, time tens.
- Segment codes for digits 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.

## Timing
**Reset values** (while `rst`=0 at a clock edge):
- `state`=IDLE, `game_rst`=1, `net_score`=0, `time_left`=GAME_SECONDS, `high_score`=0.
- `final_score`=0, digit index 0, `an`=1110, `seg`=1000000.
- All counters are 0 and `start_q`=0. A `start` held high through reset release gives no edge.
- Reset asserted mid-round aborts to IDLE on that edge and clears `high_score`.

**Latencies**
- `start` rises at edge N: `start_edge` at N+1, `state`=PLAY and `game_rst`=0 at N+2.
- `score_pos` change at edge N: `net_score` updates at N+2. The win transition is visible at N+3.
- `tick` at edge T: `time_left` or `state` updates at T+1.
- `seg` and `an` are registered and change together.

**Boundaries**
- Win and final tick in the same cycle: WIN.
- `start_edge` in the same cycle as the PLAY exit: ignored.
- `net_score` already ≥ WIN_SCORE on the first PLAY cycle cannot occur, because the inputs were in reset.

## Test plan
Bench parameters: CLK_HZ=10, GAME_SECONDS=3, WIN_SCORE=5, SEG_REFRESH=2.
- **Reset and first start.** Release reset, pulse `start`.
  - `state` goes 0→1 two cycles after the `start` rise, and `game_rst` 1→0 on the same edge.
  - `time_left`=3.
- **Timeout.** Hold `score_pos`=2, `score_neg`=0.
  - `time_left` steps 3→2→1→0 at 10-cycle intervals. `state`=3 on the edge `time_left` reaches 0.
  - `final_score`=2, `high_score`=2, `game_rst`=1.
- **Win and tie priority.** `score_pos` steps to 5 mid-round: `state`=2 three cycles later, `high_score`=5.
  - Separately, align `net_score` ≥ 5 with the final tick: `state`=2.
- **Saturation.** `score_pos`=1, `score_neg`=4: `net_score`=0.
  - A later round ending with score 3 leaves `high_score`=5.
- **Display scan.** In IDLE with `high_score`=5:
  - `an` cycles 1110, 1101, 1011, 0111 every 2 cycles.
  - `seg` shows 0010010, 1000000, 0110000, 1000000 (5, 0, 3, 0).
- **Mid-round reset.** Assert `rst` during PLAY: next edge gives `state`=0, `game_rst`=1, `high_score`=0, `time_left`=3.

Source files
------------

// File: rtl/game_score_ctrl.sv
// -----------------------------------------------------------------------------
// game_score_ctrl
//
// Game-flow controller for the falling-object game. It takes the fruit and bug
// score counters from mem_addr_gen, runs a timed round through an
// IDLE/PLAY/WIN/LOSE state machine, holds mem_addr_gen in reset outside PLAY,
// keeps a final score and a high score, and scans score and remaining time
// onto a 4-digit active-low seven-segment display.
//
// Ports
//   clk_100MHz  in   1  only clock
//   rst         in   1  synchronous reset, active low
//   start       in   1  start/advance request level (rising edge used)
//   score_pos   in   6  summed fruit score from mem_addr_gen
//   score_neg   in   6  bug score from mem_addr_gen
//   game_rst    out  1  active-high reset to mem_addr_gen (1 unless in PLAY)
//   state       out  2  0 IDLE, 1 PLAY, 2 WIN, 3 LOSE
//   net_score   out  6  live net score, saturating at 0
//   time_left   out  7  seconds remaining in the round
//   high_score  out  6  best final score since reset
//   seg         out  7  {g,f,e,d,c,b,a}, active low
//   an          out  4  digit enables, active low
// -----------------------------------------------------------------------------
module game_score_ctrl #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int GAME_SECONDS = 60,
   parameter int WIN_SCORE    = 50,
   parameter int SEG_REFRESH  = 100_000
) (
   input  logic       clk_100MHz,
   input  logic       rst,
   input  logic       start,
   input  logic [5:0] score_pos,
   input  logic [5:0] score_neg,
   output logic       game_rst,
   output logic [1:0] state,
   output logic [5:0] net_score,
   output logic [6:0] time_left,
   output logic [5:0] high_score,
   output logic [6:0] seg,
   output logic [3:0] an
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_WIN  = 2'd2,
      S_LOSE = 2'd3
   } state_t;

   localparam int TW = $clog2(CLK_HZ + 1);
   localparam int RW = $clog2(SEG_REFRESH + 1);
   localparam logic [TW-1:0] TICK_MAX = TW'(CLK_HZ - 1);
   localparam logic [RW-1:0] REF_MAX  = RW'(SEG_REFRESH - 1);
   localparam logic [6:0]    GS_T     = 7'(GAME_SECONDS);
   localparam logic [5:0]    WIN_T    = 6'(WIN_SCORE);

   // ---------------------------------------------------------------------------
   // Input registration and start edge
   // ---------------------------------------------------------------------------
   logic [5:0] sp_q, sn_q;
   logic       start_q, start_edge_q, arm_q;

   // arm_q stays low for the first cycle after reset so that a start level
   // held through reset release is not mistaken for a fresh press.
   always_ff @(posedge clk_100MHz) begin
      if (!rst) begin
         sp_q         <= '0;
         sn_q         <= '0;
         start_q      <= 1'b0;
         start_edge_q <= 1'b0;
         arm_q        <= 1'b0;
      end else begin
         sp_q         <= score_pos;
         sn_q         <= score_neg;
         start_q      <= start;
         start_edge_q <= start & ~start_q & arm_q;
         arm_q        <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Net score, saturating at zero
   // ---------------------------------------------------------------------------
   logic [5:0] net_q;

   always_ff @(posedge clk_100MHz) begin
      if (!rst) begin
         net_q <= '0;
      end else begin
         net_q <= (sp_q >= sn_q) ? (sp_q - sn_q) : 6'd0;
      end
   end

   // ---------------------------------------------------------------------------
   // Second tick: counter is held at 0 outside PLAY, so it is already clear on
   // the first PLAY cycle.
   // ---------------------------------------------------------------------------
   state_t        state_q;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick;

   assign tick = (state_q == S_PLAY) && (tick_cnt_q == TICK_MAX);

   always_comb begin
      tick_cnt_d = '0;
      if (state_q == S_PLAY && !tick) begin
         tick_cnt_d = tick_cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (!rst) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Game FSM with registered outputs. game_rst_q mirrors "next state != PLAY".
   // ---------------------------------------------------------------------------
   logic [6:0] time_left_q;
   logic [5:0] final_score_q, high_score_q;
   logic       game_rst_q;

   always_ff @(posedge clk_100MHz) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         time_left_q   <= GS_T;
         final_score_q <= '0;
         high_score_q  <= '0;
         game_rst_q    <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_edge_q) begin
                  state_q     <= S_PLAY;
                  time_left_q <= GS_T;
                  game_rst_q  <= 1'b0;
               end else begin
                  game_rst_q  <= 1'b1;
               end
            end
            S_PLAY: begin
               // Win beats a simultaneous final tick.
               if (net_q >= WIN_T) begin
                  state_q       <= S_WIN;
                  final_score_q <= net_q;
                  if (net_q > high_score_q) high_score_q <= net_q;
                  game_rst_q    <= 1'b1;
               end else if (tick && time_left_q == 7'd1) begin
                  state_q       <= S_LOSE;
                  time_left_q   <= 7'd0;
                  final_score_q <= net_q;
                  if (net_q > high_score_q) high_score_q <= net_q;
                  game_rst_q    <= 1'b1;
               end else begin
                  if (tick) time_left_q <= time_left_q - 7'd1;
                  game_rst_q <= 1'b0;
               end
            end
            default: begin // S_WIN, S_LOSE
               game_rst_q <= 1'b1;
               if (start_edge_q) begin
                  state_q     <= S_IDLE;
                  time_left_q <= GS_T;
               end
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Display: value selection, BCD split, digit scan and segment decode
   // ---------------------------------------------------------------------------
   // Compare-subtract BCD for 0..99: peel off 80, 40, 20, 10 in turn.
   function automatic logic [7:0] to_bcd(input logic [6:0] v);
      logic [6:0] r;
      logic [3:0] t;
      r = v;
      t = 4'd0;
      if (r >= 7'd80) begin r = r - 7'd80; t[3] = 1'b1; end
      if (r >= 7'd40) begin r = r - 7'd40; t[2] = 1'b1; end
      if (r >= 7'd20) begin r = r - 7'd20; t[1] = 1'b1; end
      if (r >= 7'd10) begin r = r - 7'd10; t[0] = 1'b1; end
      return {t, r[3:0]};
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   // disp_val[0] is the score, disp_val[1] is the time.
   logic [6:0] disp_val [2];
   logic [7:0] disp_bcd [2];

   always_comb begin
      disp_val[0] = {1'b0, high_score_q};
      disp_val[1] = GS_T;
      case (state_q)
         S_PLAY: begin
            disp_val[0] = {1'b0, net_q};
            disp_val[1] = time_left_q;
         end
         S_WIN, S_LOSE: begin
            disp_val[0] = {1'b0, final_score_q};
            disp_val[1] = time_left_q;
         end
         default: ;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bcd
         assign disp_bcd[gi] = to_bcd(disp_val[gi]);
      end
   endgenerate

   logic [RW-1:0] ref_cnt_q;
   logic [1:0]    digit_idx_q;
   logic [3:0]    cur_digit;
   logic [6:0]    seg_q;
   logic [3:0]    an_q;

   always_comb begin
      cur_digit = disp_bcd[0][3:0];
      case (digit_idx_q)
         2'd1:    cur_digit = disp_bcd[0][7:4];
         2'd2:    cur_digit = disp_bcd[1][3:0];
         2'd3:    cur_digit = disp_bcd[1][7:4];
         default: cur_digit = disp_bcd[0][3:0];
      endcase
   end

   always_ff @(posedge clk_100MHz) begin
      if (!rst) begin
         ref_cnt_q   <= '0;
         digit_idx_q <= 2'd0;
         seg_q       <= 7'b1000000;
         an_q        <= 4'b1110;
      end else begin
         if (ref_cnt_q == REF_MAX) begin
            ref_cnt_q   <= '0;
            digit_idx_q <= digit_idx_q + 2'd1;
         end else begin
            ref_cnt_q   <= ref_cnt_q + RW'(1);
         end
         // seg and an are loaded together from the same digit index.
         seg_q <= seg7(cur_digit);
         an_q  <= ~(4'b0001 << digit_idx_q);
      end
   end

   assign game_rst   = game_rst_q;
   assign state      = state_q;
   assign net_score  = net_q;
   assign time_left  = time_left_q;
   assign high_score = high_score_q;
   assign seg        = seg_q;
   assign an         = an_q;

endmodule

// File: tb/tb_game_score_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_score_ctrl
//
// Directed bench for game_score_ctrl with CLK_HZ=10, GAME_SECONDS=3,
// WIN_SCORE=5, SEG_REFRESH=2. Inputs are driven and outputs sampled 1 ns
// after the rising edge. The bench stands in for mem_addr_gen by driving the
// score inputs directly and zeroing them whenever a round is over.
// -----------------------------------------------------------------------------
module tb_game_score_ctrl;

   localparam logic [6:0] SEG0 = 7'b1000000;
   localparam logic [6:0] SEG2 = 7'b0100100;
   localparam logic [6:0] SEG3 = 7'b0110000;
   localparam logic [6:0] SEG5 = 7'b0010010;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [5:0] score_pos, score_neg;
   logic       game_rst;
   logic [1:0] state;
   logic [5:0] net_score;
   logic [6:0] time_left;
   logic [5:0] high_score;
   logic [6:0] seg;
   logic [3:0] an;

   int total = 0;
   int bad   = 0;

   logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0] exp_seg [4] = '{SEG5, SEG0, SEG3, SEG0};

   always #5 clk = ~clk;

   game_score_ctrl #(
      .CLK_HZ      (10),
      .GAME_SECONDS(3),
      .WIN_SCORE   (5),
      .SEG_REFRESH (2)
   ) dut (
      .clk_100MHz(clk),
      .rst       (rst),
      .start     (start),
      .score_pos (score_pos),
      .score_neg (score_neg),
      .game_rst  (game_rst),
      .state     (state),
      .net_score (net_score),
      .time_left (time_left),
      .high_score(high_score),
      .seg       (seg),
      .an        (an)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Press start from IDLE and return on the first cycle state reads PLAY.
   task automatic go_play(input string tag);
      int n = 0;
      start = 1'b1;
      while (state != 2'd1 && n < 10) begin
         step(1);
         n++;
      end
      start = 1'b0;
      check_eq(tag, state, 2'd1);
   endtask

   // From WIN/LOSE back to IDLE; scores read 0 while game_rst is high.
   task automatic go_idle(input string tag);
      int n = 0;
      score_pos = 6'd0;
      score_neg = 6'd0;
      start     = 1'b1;
      while (state != 2'd0 && n < 10) begin
         step(1);
         n++;
      end
      start = 1'b0;
      check_eq({tag, "_state"}, state, 2'd0);
      check_eq({tag, "_time"}, time_left, 7'd3);
      step(3);
   endtask

   task automatic wait_state(input string tag, input logic [1:0] want, input int bound);
      int n = 0;
      while (state != want && n < bound) begin
         step(1);
         n++;
      end
      check_eq(tag, state, want);
   endtask

   // Wait for the score-ones digit to be lit and check its segments.
   task automatic check_digit0(input string tag, input logic [6:0] want);
      int n = 0;
      while (an != 4'b1110 && n < 12) begin
         step(1);
         n++;
      end
      check_eq({tag, "_an"}, an, 4'b1110);
      check_eq({tag, "_seg"}, seg, want);
   endtask

   initial begin
      logic [3:0] prev_an;
      int         n;

      rst       = 1'b0;
      start     = 1'b0;
      score_pos = 6'd0;
      score_neg = 6'd0;
      step(3);

      // Reset state
      check_eq("rst_state", state, 2'd0);
      check_eq("rst_game_rst", game_rst, 1'b1);
      check_eq("rst_net", net_score, 6'd0);
      check_eq("rst_time", time_left, 7'd3);
      check_eq("rst_high", high_score, 6'd0);
      check_eq("rst_an", an, 4'b1110);
      check_eq("rst_seg", seg, SEG0);

      rst = 1'b1;
      step(3);

      // First start: PLAY two edges after the start rise
      score_pos = 6'd2;
      start     = 1'b1;
      step(1);
      check_eq("start_e1_state", state, 2'd0);
      check_eq("start_e1_game_rst", game_rst, 1'b1);
      step(1);
      start = 1'b0;
      check_eq("start_e2_state", state, 2'd1);
      check_eq("start_e2_game_rst", game_rst, 1'b0);
      check_eq("start_e2_time", time_left, 7'd3);

      // Timeout with net score 2
      step(9);
      check_eq("to_p9_time", time_left, 7'd3);
      step(1);
      check_eq("to_p10_time", time_left, 7'd2);
      check_eq("to_net", net_score, 6'd2);
      step(10);
      check_eq("to_p20_time", time_left, 7'd1);
      step(9);
      check_eq("to_p29_state", state, 2'd1);
      step(1);
      check_eq("to_p30_time", time_left, 7'd0);
      check_eq("to_p30_state", state, 2'd3);
      check_eq("to_game_rst", game_rst, 1'b1);
      check_eq("to_high", high_score, 6'd2);
      check_digit0("to_final", SEG2);
      go_idle("idle1");

      // Win mid-round: state WIN three edges after score change
      go_play("win_play");
      step(4);
      score_pos = 6'd5;
      step(2);
      check_eq("win_net", net_score, 6'd5);
      check_eq("win_e2_state", state, 2'd1);
      step(1);
      check_eq("win_e3_state", state, 2'd2);
      check_eq("win_high", high_score, 6'd5);
      check_eq("win_game_rst", game_rst, 1'b1);
      check_eq("win_time", time_left, 7'd3);
      go_idle("idle2");

      // Win coinciding with the final tick; start ignored during PLAY
      go_play("tie_play");
      step(3);
      start = 1'b1;
      step(3);
      check_eq("play_start_ignored", state, 2'd1);
      start = 1'b0;
      step(21);
      score_pos = 6'd5;
      step(2);
      check_eq("tie_p29_state", state, 2'd1);
      check_eq("tie_p29_time", time_left, 7'd1);
      step(1);
      check_eq("tie_p30_state", state, 2'd2);
      check_eq("tie_p30_time", time_left, 7'd1);
      check_eq("tie_high", high_score, 6'd5);
      go_idle("idle3");

      // Saturation, then a losing round with score 3
      score_pos = 6'd1;
      score_neg = 6'd4;
      go_play("sat_play");
      step(3);
      check_eq("sat_net", net_score, 6'd0);
      check_eq("sat_state", state, 2'd1);
      score_pos = 6'd3;
      score_neg = 6'd0;
      wait_state("sat_lose", 2'd3, 40);
      check_eq("sat_high", high_score, 6'd5);
      check_digit0("sat_final", SEG3);
      go_idle("idle4");

      // Display scan in IDLE: high score 5, time 3
      prev_an = an;
      n = 0;
      while (!(prev_an != 4'b1110 && an == 4'b1110) && n < 20) begin
         prev_an = an;
         step(1);
         n++;
      end
      for (int k = 0; k < 8; k++) begin
         check_eq($sformatf("scan%0d_an", k), an, exp_an[k/2]);
         check_eq($sformatf("scan%0d_seg", k), seg, exp_seg[k/2]);
         step(1);
      end

      // Mid-round reset, start held through release
      go_play("mr_play");
      step(5);
      rst   = 1'b0;
      start = 1'b1;
      step(1);
      check_eq("mr_state", state, 2'd0);
      check_eq("mr_game_rst", game_rst, 1'b1);
      check_eq("mr_high", high_score, 6'd0);
      check_eq("mr_time", time_left, 7'd3);
      check_eq("mr_an", an, 4'b1110);
      check_eq("mr_seg", seg, SEG0);
      step(2);
      rst = 1'b1;
      step(5);
      check_eq("held_start_no_edge", state, 2'd0);
      start = 1'b0;
      step(2);
      go_play("restart_play");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
